// File: rtl/anim_pkg.sv
// Shared types and constants for the LED animation sequencer.
package anim_pkg;

   localparam int unsigned FRAME_W   = 7;
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } anim_state_e;

endpackage

// File: rtl/anim_prescaler.sv
// Frame-rate prescaler: a tick every (TICK_DIV >> speed) enabled cycles.
module anim_prescaler #(
   parameter int unsigned TICK_DIV = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       tick
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period;

   assign period = CNT_W'(TICK_DIV >> speed);

   // Compare with >= so that shortening the period mid-count ticks at once.
   assign tick = en && (count_q >= period - 1'b1);

   always_comb begin
      count_d = count_q;
      if (clr || tick) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/led_anim_seq.sv
// Frame sequencer for the 7-segment LED animation.
// Build option: define ANIM_BOUNCE_EN to bounce instead of wrap when loop_en=1.
module led_anim_seq
   import anim_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 5000000,
   parameter int unsigned LAST_FRAME = 127,
   parameter logic [6:0]  BLANK      = SEG_BLANK
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               dir,
   input  logic               loop_en,
   input  logic [1:0]         speed,
   input  logic [6:0]         seg_in,
   output logic [FRAME_W-1:0] frame_idx,
   output logic [6:0]         seg_out,
   output logic               busy,
   output logic               done
);

   localparam logic [FRAME_W-1:0] LAST = FRAME_W'(LAST_FRAME);

   anim_state_e        state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [6:0]         seg_q, seg_d;
   logic               done_q, done_d;
   logic               pre_en, pre_clr, tick;
   logic               step_dir;

`ifdef ANIM_BOUNCE_EN
   logic dir_q, dir_d;
   assign step_dir = dir_q;
`else
   assign step_dir = dir;
`endif

   assign pre_en = (state_q == StRun) && !pause;

   anim_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pre_en),
      .clr   (pre_clr),
      .speed (speed),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      done_d  = 1'b0;
      pre_clr = 1'b0;
`ifdef ANIM_BOUNCE_EN
      dir_d   = dir_q;
`endif
      if (stop) begin
         state_d = StIdle;
         pre_clr = 1'b1;
      end else if (start) begin
         state_d = StRun;
         frame_d = dir ? LAST : '0;
         pre_clr = 1'b1;
`ifdef ANIM_BOUNCE_EN
         dir_d   = dir;
`endif
      end else begin
         case (state_q)
            StRun: begin
               if (pause) begin
                  state_d = StPause;
               end else if (tick) begin
                  if (frame_q == (step_dir ? '0 : LAST)) begin
                     if (loop_en) begin
`ifdef ANIM_BOUNCE_EN
                        dir_d   = !dir_q;
                        frame_d = dir_q ? frame_q + 1'b1 : frame_q - 1'b1;
`else
                        frame_d = step_dir ? LAST : '0;
`endif
                     end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                     end
                  end else begin
                     frame_d = step_dir ? frame_q - 1'b1 : frame_q + 1'b1;
                  end
               end
            end
            StPause: begin
               if (!pause) state_d = StRun;
            end
            default: ;
         endcase
      end
   end

   // Blank on the edge that enters IDLE and while sitting in it.
   assign seg_d = (state_q == StIdle || state_d == StIdle) ? BLANK : seg_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         frame_q <= '0;
         seg_q   <= BLANK;
         done_q  <= 1'b0;
`ifdef ANIM_BOUNCE_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         seg_q   <= seg_d;
         done_q  <= done_d;
`ifdef ANIM_BOUNCE_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign frame_idx = frame_q;
   assign seg_out   = seg_q;
   assign busy      = (state_q == StRun) || (state_q == StPause);
   assign done      = done_q;

endmodule
